// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
//
// Multi-digit packed-BCD countdown timer. A start value is loaded, then the
// count steps down by one on every qualified tick (x) while running. Reaching
// zero from one raises a one-cycle done pulse and parks the timer in DONE.
//
// Optional feature macro: BCD_DOWN_TIMER_AUTORELOAD_EN
//   When defined, terminal count reloads the last loaded value instead of
//   entering DONE, so the timer becomes a periodic N-tick divider.
//
// Parameters:
//   DIGITS     number of BCD digits (1..8)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   x          count tick enable
//   load       load load_val (illegal digits saturate to 9), go to IDLE
//   load_val   packed BCD start value, digit 0 in bits [3:0]
//   start      begin or resume counting
//   stop       pause counting
//   bcd_out    current count, packed BCD, digit 0 in bits [3:0]
//   running    high while in RUN
//   zero       high while the count is all zeros
//   done       one-cycle registered pulse on terminal count
//   state_dbg  current FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//
// Input priority each cycle: load > stop > start > x.
// ---------------------------------------------------------------------------
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  x,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  zero,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   load_sat;
    logic [W-1:0]   count_dec;
    logic           done_q, done_d;
    logic           count_one;
    logic           tick;
    logic           borrow;

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
    logic [W-1:0]   reload_q, reload_d;
`endif

    // Saturate any non-BCD digit of the load value to 9.
    always_comb begin
        load_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Decrement with a combinational borrow ripple: a digit at 0 wraps to 9
    // and passes the borrow upward; the first nonzero digit absorbs it.
    always_comb begin
        count_dec = count_q;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    assign zero      = (count_q == '0);
    assign count_one = (count_q == W'(1));
    // The zero guard keeps the count from ever wrapping below 0.
    assign tick      = (state_q == RUN) && x && !zero;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            count_d = load_sat;
            state_d = IDLE;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
            reload_d = load_sat;
`endif
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start && ((state_q == IDLE && !zero) || state_q == PAUSE)) begin
            // Entering RUN consumes the cycle: a coincident x does not count.
            state_d = RUN;
        end else if (tick) begin
            if (count_one) begin
                done_d = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = DONE;
`endif
            end else begin
                count_d = count_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign bcd_out   = count_q;
    assign running   = (state_q == RUN);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_down_timer
//
// Directed bench for bcd_down_timer (DIGITS=4). A table of per-cycle input
// vectors with hand-computed expected outputs is applied in order, followed
// by hand-written sequences for the countdown/terminal pulse, auto-reload
// (when BCD_DOWN_TIMER_AUTORELOAD_EN is defined) and asynchronous reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_down_timer;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          x, load, start, stop;
    logic [W-1:0]  load_val;
    logic [W-1:0]  bcd_out;
    logic          running, zero, done;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .stop      (stop),
        .bcd_out   (bcd_out),
        .running   (running),
        .zero      (zero),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic st,
                         input logic sp, input logic xx);
        @(negedge clk);
        load     = ld;
        load_val = lv;
        start    = st;
        stop     = sp;
        x        = xx;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          ld;
        logic [W-1:0]  lv;
        logic          st;
        logic          sp;
        logic          xx;
        logic [W-1:0]  e_bcd;
        logic          e_run;
        logic          e_done;
        logic          e_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic st,
                                input logic sp, input logic xx, input logic [W-1:0] e_bcd,
                                input logic e_run, input logic e_done, input logic e_zero);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.xx = xx;
        v.e_bcd = e_bcd; v.e_run = e_run; v.e_done = e_done; v.e_zero = e_zero;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; x = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;

        //                ld  load_val  st  sp  x    bcd       run  done zero
        vecs.push_back(mk(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0));   // load
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0));   // start
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0999, 1, 0, 0));   // full borrow chain
        vecs.push_back(mk(1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0099, 1, 0, 0));   // two-digit borrow
        vecs.push_back(mk(1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0005, 1, 0, 0));   // start+x: no decrement
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0004, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0003, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0003, 0, 0, 0));   // stop beats x
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0003, 0, 0, 0));   // paused ticks held
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0003, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0003, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0, 0));   // resume
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0005, 1, 1, 0));   // terminal reloads 0005
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0004, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0004, 1, 0, 0));   // start while running
`else
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1));   // terminal count
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1));   // done falls, held
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));   // start ignored in DONE
`endif
        vecs.push_back(mk(1, 16'h0012, 1, 0, 0, 16'h0012, 0, 0, 0));   // load beats start
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0012, 1, 0, 0));
        vecs.push_back(mk(1, 16'h00A7, 0, 0, 1, 16'h0097, 0, 0, 0));   // load beats x, A->9
        vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));   // start with 0 ignored
        vecs.push_back(mk(1, 16'hFFFF, 0, 0, 0, 16'h9999, 0, 0, 0));   // all digits saturate
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h9999, 0, 0, 0));   // stop beats start

        // Reset state: two edges under reset so the async branch has certainly applied.
        repeat (2) @(posedge clk);
        #1;
        chk("rst bcd",     32'(bcd_out),   32'h0);
        chk("rst running", 32'(running),   32'h0);
        chk("rst done",    32'(done),      32'h0);
        chk("rst zero",    32'(zero),      32'h1);
        chk("rst state",   32'(state_dbg), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].xx);
            chk($sformatf("vec%0d bcd", i),     32'(bcd_out), 32'(vecs[i].e_bcd));
            chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_run));
            chk($sformatf("vec%0d done", i),    32'(done),    32'(vecs[i].e_done));
            chk($sformatf("vec%0d zero", i),    32'(zero),    32'(vecs[i].e_zero));
        end

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        // Auto-reload: 0003 gives a 3-tick period, 0 never shown.
        drive(1, 16'h0003, 0, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        chk("ar initial", 32'(bcd_out), 32'h0003);
        for (int t = 1; t <= 7; t++) begin
            exp_q.push_back(to_bcd((t % 3 == 0) ? 3 : 3 - (t % 3)));
            drive(0, 16'h0000, 0, 0, 1);
            chk($sformatf("ar t%0d bcd", t),     32'(bcd_out), 32'(exp_q.pop_front()));
            chk($sformatf("ar t%0d done", t),    32'(done),    32'((t % 3) == 0));
            chk($sformatf("ar t%0d running", t), 32'(running), 32'h1);
        end
`else
        // Basic countdown from 0012 with terminal pulse and hold.
        drive(1, 16'h0012, 0, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        for (int t = 1; t <= 12; t++) begin
            exp_q.push_back(to_bcd(12 - t));
            drive(0, 16'h0000, 0, 0, 1);
            chk($sformatf("cd t%0d bcd", t),     32'(bcd_out), 32'(exp_q.pop_front()));
            chk($sformatf("cd t%0d done", t),    32'(done),    32'(t == 12));
            chk($sformatf("cd t%0d running", t), 32'(running), 32'(t != 12));
        end
        chk("cd state done", 32'(state_dbg), 32'h3);
        for (int t = 0; t < 2; t++) begin
            drive(0, 16'h0000, 0, 0, 1);
            chk($sformatf("cd hold%0d bcd", t),  32'(bcd_out), 32'h0);
            chk($sformatf("cd hold%0d done", t), 32'(done),    32'h0);
        end
`endif

        // Asynchronous reset between edges while running at 0456.
        drive(1, 16'h0456, 0, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        chk("ar0 running", 32'(running), 32'h1);
        chk("ar0 bcd",     32'(bcd_out), 32'h0456);
        @(negedge clk);
        start = 1'b0;
        x     = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("async bcd",     32'(bcd_out), 32'h0);
        chk("async zero",    32'(zero),    32'h1);
        chk("async running", 32'(running), 32'h0);
        chk("async done",    32'(done),    32'h0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst bcd",     32'(bcd_out), 32'h0);
        chk("post rst running", 32'(running), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Multi-digit BCD countdown timer: loads a packed BCD start value, decrements by one on each qualified tick while running, and flags terminal count. It is the counting-down counterpart of the single-digit BCD up counters used in the display/counter path. It drives the same 4-bit-per-digit display decoders and shares their tick source.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. One clock domain only.
- x  input  1  count tick enable; sampled each clk edge.
- load  input  1  load load_val into count and reload registers.
- load_val  input  4*DIGITS  packed BCD start value; digit 0 is in bits [3:0].
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- bcd_out  output  4*DIGITS  current count, packed BCD; digit 0 is in bits [3:0].
- running  output  1  high while in RUN.
- zero  output  1  high while bcd_out is all zeros (combinational from the count register).
- done  output  1  one-cycle pulse on terminal count.

## Operation
- Reset value of every output while reset=0:
  - bcd_out = 0, reload register = 0.
  - State = IDLE, so running = 0.
  - done = 0, zero = 1.
- States and transitions:
  - IDLE: on start with count ≠ 0, go to RUN. A start with count = 0 is ignored.
  - RUN: on stop, go to PAUSE. On terminal count, go to DONE (or stay in RUN, see Configuration).
  - PAUSE: on start, go to RUN. Count is held.
  - DONE: count is held at 0. Only load leaves DONE; start is ignored.
- Per-cycle input priority: load > stop > start > x.
- load, in any state:
  - count ← load_val and reload ← load_val.
  - State ← IDLE. done is not pulsed.
  - Any digit > 9 in load_val is stored as 9.
- Decrement occurs when state is RUN, x = 1, and no load or stop is present in the same cycle.
  - Digit 0 steps 9→8→…→0.
  - A digit stepping 0→9 borrows from the next digit. The borrow ripples combinationally within one cycle, e.g. 1000 → 0999.
  - Counts never pass through non-BCD codes and never underflow below 0.
- start and x in the same cycle from IDLE or PAUSE: state becomes RUN, no decrement that cycle.
- Terminal count is a decrement that takes the count from 1 to 0 (all upper digits already 0). On that edge:
  - done = 1 for exactly one cycle, coincident with the register update.
  - State ← DONE, running ← 0, bcd_out = 0.

## Timing
- All state, count and done updates are on the rising clk edge. Each change is visible one cycle after the qualifying input sample.
- Decrement latency is one cycle per tick: bcd_out changes on the edge that samples x = 1.
- done is registered. It rises on the same edge that writes the terminal count and falls on the next edge.
- running and zero are decoded from registers, so they carry no extra latency.
- Reset asserted mid-count: outputs go to their reset values immediately (asynchronous). Counting resumes only after a new load and start.
- Reset release is synchronised to clk by the surrounding design; the block does not synchronise it.

## Configuration
- Macro: BCD_DOWN_TIMER_AUTORELOAD_EN.
- When defined, terminal count does not enter DONE:
  - count ← reload register, done pulses for one cycle, and state stays RUN.
  - The period is therefore N ticks for a loaded value N. Count 0 is never shown while auto-reloading.
  - DONE is reachable only if reload = 0, which cannot occur in RUN.
- When undefined: behaviour is exactly as described in Operation. The reload register may be optimised away.

## Test plan
- Basic countdown: DIGITS=4, load 0012, start, 12 ticks of x.
  - bcd_out steps 0012, 0011, 0010, 0009 … 0001, 0000.
  - done pulses once on the 12th tick; running drops; further ticks hold 0000.
- Borrow chain: load 1000, start, 1 tick → bcd_out = 0999. Load 0100, start, 1 tick → 0099.
- Pause and resume: load 0005, start, 2 ticks → 0003.
  - stop and x together → holds 0003, running = 0.
  - 3 ticks while paused → still 0003.
  - start, then 3 ticks → 0000 with a done pulse.
- Priority and illegal digits:
  - In RUN, assert load=1 with load_val 00A7 and x=1 in the same cycle → bcd_out = 0097, state IDLE, no decrement, no done.
  - start with count 0000 → remains IDLE, running = 0.
- Asynchronous reset mid-run: at count 0456 with running = 1, pulse reset low between edges → bcd_out = 0000, zero = 1, running = 0, done = 0, with no clock edge required.
- Auto-reload (macro defined): load 0003, start, 7 ticks.
  - Sequence: 0003, 0002, 0001, 0003, 0002, 0001, 0003, 0002.
  - done pulses on ticks 3 and 6; running stays 1 throughout.
